cluster_unpacker: RTL and testbench

CLUSTER_UNPACKER -- requirements
Module: cluster_unpacker

---
 rtl/cluster_unpacker.sv | 142 ++++++++++++++
 tb/tb_cluster_unpacker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cluster_unpacker.sv
// Rebuilds an S-bit pad map from a stream of cluster words and presents one map per frame.
// Define CLUSTER_UNPACK_OVERLAP_ERR_EN to add the err_overlap output.
//
//   state   | meaning
//   ACCUM   | accepting cluster words and ORing them into the map
//   PRESENT | frame complete, map held on out_sbits until out_ready
module cluster_unpacker #(
  parameter int MXPAD   = 1536,
  parameter int MXCLUST = 8,
  localparam int NCW    = $clog2(MXCLUST + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_cluster,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MXPAD-1:0] out_sbits,
  output logic [NCW-1:0]   out_nclust,
  output logic             err_adr,
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
  output logic             err_overlap,
`endif
  output logic             err_ovf
);

  typedef enum logic {ACCUM, PRESENT} state_t;

  localparam logic [11:0]    PAD_LIM  = 12'(MXPAD);
  localparam logic [NCW-1:0] CLUST_MX = NCW'(MXCLUST);

  state_t           state_q, state_d;
  logic [MXPAD-1:0] map_q, map_d;
  logic [NCW-1:0]   nclust_q, nclust_d;
  logic             err_adr_q, err_adr_d;
  logic             err_ovf_q, err_ovf_d;
  logic [MXPAD-1:0] run_w, mask;
  logic [7:0]       run;
  logic [10:0]      adr;
  logic [2:0]       cnt;
  logic             xfer, is_null, adr_bad, full;

  assign adr     = in_cluster[10:0];
  assign cnt     = in_cluster[13:11];
  assign is_null = (adr == 11'h7FF);
  assign adr_bad = !is_null && ({1'b0, adr} >= PAD_LIM);
  assign full    = (nclust_q == CLUST_MX);
  assign xfer    = in_valid && in_ready;

  // cnt+1 ones shifted up to the first pad; anything past the top pad falls off
  assign run = 8'hFF >> (3'd7 - cnt);
  always_comb begin
    run_w      = '0;
    run_w[7:0] = run;
    mask       = run_w << adr;
  end

`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
  logic err_ovl_q, err_ovl_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    nclust_d  = nclust_q;
    err_adr_d = err_adr_q;
    err_ovf_d = err_ovf_q;
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
    err_ovl_d = err_ovl_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (!is_null) begin
            if (adr_bad) err_adr_d = 1'b1;
            if (full)    err_ovf_d = 1'b1;
            if (!adr_bad && !full) begin
              map_d    = map_q | mask;
              nclust_d = nclust_q + 1'b1;
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
              if (|(map_q & mask)) err_ovl_d = 1'b1;
`endif
            end
          end
          if (in_last) state_d = PRESENT;
        end
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d   = ACCUM;
          map_d     = '0;
          nclust_d  = '0;
          err_adr_d = 1'b0;
          err_ovf_d = 1'b0;
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
          err_ovl_d = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_q     <= '0;
      nclust_q  <= '0;
      err_adr_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      map_q     <= map_d;
      nclust_q  <= nclust_d;
      err_adr_q <= err_adr_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_ovl_q <= 1'b0;
    else          err_ovl_q <= err_ovl_d;
  end
  assign err_overlap = err_ovl_q;
`endif

  assign out_sbits  = map_q;
  assign out_nclust = nclust_q;
  assign err_adr    = err_adr_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed bench for cluster_unpacker: one task per scenario, inline checks, one summary line.
module tb_cluster_unpacker;
  localparam int MXPAD   = 1536;
  localparam int MXCLUST = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready, in_last;
  logic [13:0]      in_cluster;
  logic             out_valid, out_ready;
  logic [MXPAD-1:0] out_sbits;
  logic [3:0]       out_nclust;
  logic             err_adr, err_ovf;
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
  logic             err_overlap;
`endif

  int errors = 0;
  int checks = 0;
  logic [MXPAD-1:0] exp_map;

  cluster_unpacker #(.MXPAD(MXPAD), .MXCLUST(MXCLUST)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cluster (in_cluster),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sbits  (out_sbits),
    .out_nclust (out_nclust),
    .err_adr    (err_adr),
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
    .err_overlap(err_overlap),
`endif
    .err_ovf    (err_ovf)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // called 1 time unit after a rising edge; returns 1 unit after the transfer edge
  task automatic send(input int adr, input int cnt, input bit last);
    in_valid   = 1'b1;
    in_cluster = {cnt[2:0], adr[10:0]};
    in_last    = last;
    @(posedge clock); #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_cluster = '0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_sbits !== '0) begin errors++; $display("FAIL reset_map: got %0d bits set want 0", $countones(out_sbits)); end
    checks++; if (out_nclust !== 4'd0 || err_adr !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err: got nclust=%0d adr=%b ovf=%b want 0 0 0", out_nclust, err_adr, err_ovf);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    send(10, 2, 1'b1);
    exp_map = '0; exp_map[12:10] = 3'b111;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_sbits !== exp_map) begin errors++; $display("FAIL basic_map: got %0d bits set, %0d wrong", $countones(out_sbits), $countones(out_sbits ^ exp_map)); end
    checks++; if (out_nclust !== 4'd1 || err_adr !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL basic_cnt_err: got nclust=%0d adr=%b ovf=%b want 1 0 0", out_nclust, err_adr, err_ovf);
    end
    consume();
  endtask

  task automatic test_top_clip();
    send(1534, 7, 1'b1);
    exp_map = '0; exp_map[1535:1534] = 2'b11;
    checks++; if (out_sbits !== exp_map) begin errors++; $display("FAIL clip_map: got %0d bits set, %0d wrong", $countones(out_sbits), $countones(out_sbits ^ exp_map)); end
    checks++; if (out_nclust !== 4'd1) begin errors++; $display("FAIL clip_nclust: got %0d want 1", out_nclust); end
    consume();
  endtask

  task automatic test_overflow();
    exp_map = '0;
    for (int i = 0; i < 9; i++) begin
      send(i * 20, 0, i == 8);
      if (i < 8) exp_map[i * 20] = 1'b1;
    end
    checks++; if (out_sbits !== exp_map) begin errors++; $display("FAIL ovf_map: got %0d bits set, %0d wrong", $countones(out_sbits), $countones(out_sbits ^ exp_map)); end
    checks++; if (out_nclust !== 4'd8) begin errors++; $display("FAIL ovf_nclust: got %0d want 8", out_nclust); end
    checks++; if (err_ovf !== 1'b1 || err_adr !== 1'b0) begin errors++; $display("FAIL ovf_flags: got ovf=%b adr=%b want 1 0", err_ovf, err_adr); end
    consume();
  endtask

  task automatic test_bad_addr();
    send(1600, 3, 1'b0);
    send(11'h7FF, 0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sbits !== '0) begin errors++; $display("FAIL badadr_map: got valid=%b %0d bits set want 1 0", out_valid, $countones(out_sbits)); end
    checks++; if (out_nclust !== 4'd0) begin errors++; $display("FAIL badadr_nclust: got %0d want 0", out_nclust); end
    checks++; if (err_adr !== 1'b1 || err_ovf !== 1'b0) begin errors++; $display("FAIL badadr_flags: got adr=%b ovf=%b want 1 0", err_adr, err_ovf); end
    consume();
  endtask

  task automatic test_null_only();
    send(11'h7FF, 5, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sbits !== '0 || out_nclust !== 4'd0) begin
      errors++; $display("FAIL null_frame: got valid=%b bits=%0d nclust=%0d want 1 0 0", out_valid, $countones(out_sbits), out_nclust);
    end
    checks++; if (err_adr !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL null_flags: got adr=%b ovf=%b want 0 0", err_adr, err_ovf); end
    consume();
  endtask

  task automatic test_merge();
    send(10, 3, 1'b0);
    send(12, 2, 1'b1);
    exp_map = '0; exp_map[14:10] = 5'h1F;
    checks++; if (out_sbits !== exp_map) begin errors++; $display("FAIL merge_map: got %0d bits set, %0d wrong", $countones(out_sbits), $countones(out_sbits ^ exp_map)); end
    checks++; if (out_nclust !== 4'd2) begin errors++; $display("FAIL merge_nclust: got %0d want 2", out_nclust); end
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
    checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL merge_overlap: got %b want 1", err_overlap); end
`endif
    consume();
`ifdef CLUSTER_UNPACK_OVERLAP_ERR_EN
    checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL overlap_clear: got %b want 0", err_overlap); end
`endif
  endtask

  task automatic test_ignore_invalid();
    in_valid = 1'b0; in_cluster = {3'd1, 11'd50}; in_last = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0 || out_sbits !== '0) begin errors++; $display("FAIL ignore_idle: got valid=%b bits=%0d want 0 0", out_valid, $countones(out_sbits)); end
    send(3, 0, 1'b1);
    exp_map = '0; exp_map[3] = 1'b1;
    checks++; if (out_sbits !== exp_map || out_nclust !== 4'd1) begin
      errors++; $display("FAIL ignore_frame: got bits=%0d nclust=%0d want bit 3 only, 1", $countones(out_sbits), out_nclust);
    end
    consume();
  endtask

  task automatic test_backpressure();
    send(10, 2, 1'b1);
    exp_map = '0; exp_map[12:10] = 3'b111;
    in_valid = 1'b1; in_cluster = {3'd0, 11'd100}; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_hs[%0d]: got in_ready=%b out_valid=%b want 0 1", i, in_ready, out_valid); end
      checks++; if (out_sbits !== exp_map || out_nclust !== 4'd1) begin
        errors++; $display("FAIL hold_data[%0d]: got bits=%0d nclust=%0d want 3 1", i, $countones(out_sbits), out_nclust);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL release_hs: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    checks++; if (out_sbits !== '0 || out_nclust !== 4'd0) begin errors++; $display("FAIL release_clear: got bits=%0d nclust=%0d want 0 0", $countones(out_sbits), out_nclust); end
  endtask

  task automatic test_mid_reset();
    send(100, 1, 1'b0);
    send(200, 1, 1'b0);
    send(300, 1, 1'b0);
    checks++; if ($countones(out_sbits) != 6 || out_nclust !== 4'd3) begin
      errors++; $display("FAIL partial_map: got bits=%0d nclust=%0d want 6 3", $countones(out_sbits), out_nclust);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sbits !== '0 || out_nclust !== 4'd0) begin
      errors++; $display("FAIL async_clear: got valid=%b bits=%0d nclust=%0d want 0 0 0", out_valid, $countones(out_sbits), out_nclust);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    send(5, 0, 1'b1);
    exp_map = '0; exp_map[5] = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_sbits !== exp_map || out_nclust !== 4'd1) begin
      errors++; $display("FAIL post_reset: got valid=%b bits=%0d nclust=%0d want 1, bit 5 only, 1", out_valid, $countones(out_sbits), out_nclust);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_clip();
    test_overflow();
    test_bad_addr();
    test_null_only();
    test_merge();
    test_ignore_invalid();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
